// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data-memory stage and its storage array.
package dmem_pkg;
    typedef enum logic {IDLE, WAIT} dmem_state_t;

    localparam int DEF_ADDR_W      = 8;
    localparam int DEF_WAIT_STATES = 2;

    typedef logic [DEF_ADDR_W-1:0] word_addr_t;
endpackage

// File: rtl/dmem_array.sv
// Word storage with asynchronous clear, one synchronous write port and one combinational read port.
// Latency: write commits on the clock edge, read is same-cycle; no backpressure.
module dmem_array #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2**ADDR_W; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/dmem_stage.sv
// Data-memory stage: serves loads/stores from local storage with WAIT_STATES extra cycles per access.
// Latency: WAIT_STATES+1 cycles per access; stall holds the PC until the completion cycle.
module dmem_stage import dmem_pkg::*; #(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = 32,
    parameter int WAIT_STATES = DEF_WAIT_STATES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [31:0]       addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              done,
    output logic              stall,
    output logic              err
);
    localparam bit ZERO_WS = (WAIT_STATES == 0);
    localparam int CW      = (WAIT_STATES < 2) ? 1 : $clog2(WAIT_STATES + 1);

    dmem_state_t       state;
    logic [CW-1:0]     cnt;
    logic [ADDR_W-1:0] live_idx;
    logic [ADDR_W-1:0] lat_idx;
    logic [ADDR_W-1:0] wr_idx;
    logic [ADDR_W-1:0] rd_idx;
    logic [DATA_W-1:0] lat_wdata;
    logic [DATA_W-1:0] wr_data;
    logic              lat_wr;
    logic              req;
    logic              accept;
    logic              last;
    logic              we;
    logic              bad_req;
    logic              unused_addr;

    // Upper address bits are dropped so accesses wrap modulo the array depth.
    assign live_idx    = addr[ADDR_W+1:2];
    assign unused_addr = ^addr[31:ADDR_W+2];

    assign req     = mem_read | mem_write;
    assign accept  = (state == IDLE) && req && !rst;
    assign last    = (state == WAIT) && (cnt == CW'(1));
    assign bad_req = (mem_read & mem_write) | (addr[1:0] != 2'b00);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            lat_idx   <= '0;
            lat_wdata <= '0;
            lat_wr    <= 1'b0;
            err       <= 1'b0;
        end else begin
            if (accept && bad_req) begin
                err <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (accept && !ZERO_WS) begin
                        state     <= WAIT;
                        cnt       <= CW'(WAIT_STATES);
                        lat_idx   <= live_idx;
                        lat_wdata <= wdata;
                        lat_wr    <= mem_write;
                    end
                end
                WAIT: begin
                    cnt <= cnt - CW'(1);
                    if (last) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A read+write request is a store: lat_wr/we follow mem_write alone.
    assign done    = ZERO_WS ? accept : last;
    assign stall   = !ZERO_WS && (accept || ((state == WAIT) && !last));
    assign we      = ZERO_WS ? (accept && mem_write) : (last && lat_wr);
    assign wr_idx  = ZERO_WS ? live_idx : lat_idx;
    assign wr_data = ZERO_WS ? wdata : lat_wdata;
    assign rd_idx  = (state == WAIT) ? lat_idx : live_idx;

    dmem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (we),
        .waddr (wr_idx),
        .wdata (wr_data),
        .raddr (rd_idx),
        .rdata (rdata)
    );
endmodule

// File: tb/tb_dmem_stage.sv
// Scoreboard bench for dmem_stage with WAIT_STATES=2 and WAIT_STATES=0 instances side by side.
module tb_dmem_stage;
    import dmem_pkg::*;

    localparam int WS    = DEF_WAIT_STATES;
    localparam int DEPTH = 256;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        a2_rd, a2_wr, a0_rd, a0_wr;
    logic [31:0] a2_addr, a2_wdata, a0_addr, a0_wdata;
    logic [31:0] d2_rdata, d0_rdata;
    logic        d2_done, d2_stall, d2_err;
    logic        d0_done, d0_stall, d0_err;

    logic [31:0] m2 [DEPTH];
    logic [31:0] m0 [DEPTH];
    bit          e2, e0;
    exp_t        q2[$];
    exp_t        q0[$];
    int          n_cmp;
    int          n_fail;

    dmem_stage #(.ADDR_W(8), .DATA_W(32), .WAIT_STATES(WS)) dut2 (
        .clk(clk), .rst(rst), .mem_read(a2_rd), .mem_write(a2_wr), .addr(a2_addr),
        .wdata(a2_wdata), .rdata(d2_rdata), .done(d2_done), .stall(d2_stall), .err(d2_err)
    );

    dmem_stage #(.ADDR_W(8), .DATA_W(32), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst(rst), .mem_read(a0_rd), .mem_write(a0_wr), .addr(a0_addr),
        .wdata(a0_wdata), .rdata(d0_rdata), .done(d0_done), .stall(d0_stall), .err(d0_err)
    );

    always #5 clk = ~clk;

    task automatic check_word(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    function automatic word_addr_t widx(input logic [31:0] a);
        return word_addr_t'((a >> 2) % DEPTH);
    endfunction

    task automatic clear_models();
        for (int i = 0; i < DEPTH; i++) begin
            m2[i] = '0;
            m0[i] = '0;
        end
        e2 = 0;
        e0 = 0;
    endtask

    // Monitors: pop one expectation per completed access.
    always @(negedge clk) begin : mon2
        exp_t e;
        if (!rst && d2_done === 1'b1) begin
            if (q2.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL ws2_unexpected_done: got done=1 expected no access pending");
            end else begin
                e = q2.pop_front();
                check_word("ws2_rdata", d2_rdata, e.rdata);
                check_bit("ws2_err", d2_err, e.err);
            end
        end
    end

    always @(negedge clk) begin : mon0
        exp_t e;
        if (!rst && d0_done === 1'b1) begin
            if (q0.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL ws0_unexpected_done: got done=1 expected no access pending");
            end else begin
                e = q0.pop_front();
                check_word("ws0_rdata", d0_rdata, e.rdata);
                check_bit("ws0_err", d0_err, e.err);
            end
        end
    end

    // Entered and left at posedge+1; the WAIT_STATES=2 instance sees one request then garbage.
    task automatic issue2(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        e.rdata = m2[widx(a)];
        if (wr) m2[widx(a)] = d;
        e2 = e2 | (rd & wr) | ((a % 4) != 0);
        e.err = e2;
        q2.push_back(e);
        a2_rd = rd; a2_wr = wr; a2_addr = a; a2_wdata = d;
        for (int k = 0; k <= WS; k++) begin
            @(negedge clk);
            if (k < WS) begin
                check_bit("ws2_stall_wait", d2_stall, 1'b1);
                check_bit("ws2_done_early", d2_done, 1'b0);
            end else begin
                check_bit("ws2_stall_done", d2_stall, 1'b0);
                check_bit("ws2_done", d2_done, 1'b1);
            end
            @(posedge clk);
            #1;
            if (k < WS) begin
                a2_rd = 1'($urandom); a2_wr = 1'($urandom);
                a2_addr = $urandom; a2_wdata = $urandom;
            end else begin
                a2_rd = 0; a2_wr = 0;
            end
        end
    endtask

    task automatic issue0(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        e.rdata = m0[widx(a)];
        e.err = e0;
        if (wr) m0[widx(a)] = d;
        e0 = e0 | (rd & wr) | ((a % 4) != 0);
        q0.push_back(e);
        a0_rd = rd; a0_wr = wr; a0_addr = a; a0_wdata = d;
        @(negedge clk);
        check_bit("ws0_stall", d0_stall, 1'b0);
        check_bit("ws0_done", d0_done, 1'b1);
        @(posedge clk);
        #1;
        a0_rd = 0; a0_wr = 0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            a2_rd = 0; a2_wr = 0; a2_addr = $urandom;
            a0_rd = 0; a0_wr = 0; a0_addr = $urandom;
            @(negedge clk);
            check_word("ws2_idle_rdata", d2_rdata, m2[widx(a2_addr)]);
            check_word("ws0_idle_rdata", d0_rdata, m0[widx(a0_addr)]);
            check_bit("ws2_idle_stall", d2_stall, 1'b0);
            check_bit("ws2_idle_done", d2_done, 1'b0);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_bit({tag, "_stall"}, d2_stall, 1'b0);
        check_bit({tag, "_done"}, d2_done, 1'b0);
        check_bit({tag, "_err"}, d2_err, 1'b0);
        check_word({tag, "_rdata"}, d2_rdata, 32'h0);
        check_bit({tag, "_ws0_done"}, d0_done, 1'b0);
        check_bit({tag, "_ws0_err"}, d0_err, 1'b0);
        check_word({tag, "_ws0_rdata"}, d0_rdata, 32'h0);
    endtask

    task automatic rand_access(input bit allow_err, input bit use_ws0);
        bit          rd, wr;
        logic [31:0] a;
        rd = 1'($urandom);
        wr = !rd;
        if (allow_err && $urandom_range(0, 7) == 0) begin
            rd = 1; wr = 1;
        end
        a = ($urandom & 32'hFFFF_FC00) | (32'($urandom_range(0, 15)) << 2);
        if (allow_err && $urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 3));
        if (use_ws0) issue0(rd, wr, a, $urandom);
        else         issue2(rd, wr, a, $urandom);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0; n_fail = 0;
        clk = 0; rst = 1;
        a2_rd = 0; a2_wr = 0; a2_addr = 0; a2_wdata = 0;
        a0_rd = 0; a0_wr = 0; a0_addr = 0; a0_wdata = 0;
        clear_models();
        #1;
        check_reset_outputs("reset_init");
        @(negedge clk); rst = 0;
        @(posedge clk); #1;

        // Dirty some words, then reset asynchronously mid-cycle.
        issue2(0, 1, 32'h14, 32'hCAFE_0005);
        issue0(0, 1, 32'h14, 32'hCAFE_1005);
        #2 rst = 1;
        #1 check_reset_outputs("reset_async");
        clear_models();
        @(negedge clk); rst = 0;
        @(posedge clk); #1;
        issue2(1, 0, 32'h14, 32'h0);

        // Store/load timing and store-then-load to the same word.
        issue2(0, 1, 32'h10, 32'hDEAD_BEEF);
        check_word("word4_after_store", dut2.u_array.mem[4], 32'hDEAD_BEEF);
        issue2(1, 0, 32'h10, 32'h0);
        issue2(0, 1, 32'h10, 32'h1234_5678);
        issue2(1, 0, 32'h10, 32'h0);
        idle(2);

        // Wrap from the last word to word 0.
        issue2(0, 1, 32'h3FC, 32'hAAAA_0001);
        issue2(0, 1, 32'h400, 32'hBBBB_0002);
        issue2(1, 0, 32'h0, 32'h0);
        issue2(1, 0, 32'h3FC, 32'h0);

        // Zero-wait-state configuration, back to back.
        issue0(0, 1, 32'h0, 32'h1);
        issue0(1, 0, 32'h0, 32'h0);
        idle(1);

        for (int i = 0; i < 120; i++) begin
            rand_access(0, 0);
            if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 2)));
        end
        for (int i = 0; i < 120; i++) begin
            rand_access(0, 1);
            if ($urandom_range(0, 2) == 0) idle(1);
        end

        // Error cases: misaligned load, then read+write treated as a store.
        issue2(1, 0, 32'h13, 32'h0);
        idle(2);
        check_bit("ws2_err_sticky", d2_err, 1'b1);
        issue2(1, 1, 32'h40, 32'h7777_0040);
        issue2(1, 0, 32'h40, 32'h0);
        issue0(1, 1, 32'h44, 32'h6666_0044);
        issue0(1, 0, 32'h44, 32'h0);
        idle(1);
        check_bit("ws0_err_sticky", d0_err, 1'b1);

        for (int i = 0; i < 100; i++) begin
            rand_access(1, i[0]);
            if ($urandom_range(0, 3) == 0) idle(1);
        end

        // Reset in the middle of a store's wait period.
        a2_rd = 0; a2_wr = 1; a2_addr = 32'h20; a2_wdata = 32'h55;
        @(negedge clk);
        check_bit("abort_stall_t", d2_stall, 1'b1);
        @(posedge clk); #1;
        a2_wr = 0;
        #2 rst = 1;
        #1 check_reset_outputs("reset_mid_wait");
        clear_models();
        @(negedge clk); rst = 0;
        @(posedge clk); #1;
        issue2(1, 0, 32'h20, 32'h0);
        idle(2);

        check_word("ws2_queue_drained", 32'(q2.size()), 32'h0);
        check_word("ws0_queue_drained", 32'(q0.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
